// File: rtl/ram_arbiter.sv
// Two-port arbiter for the shared single-port system RAM (CPU vs. program loader/DMA).
// Round-robin by default; define RAM_ARB_CPU_PRIORITY_EN for CPU priority with a DMA starvation guard.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  clock,
  input  logic                  bReset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  state_t                  state_r, state_s;
  logic                    winner_r, winner_s;
  logic                    rr_last_r, rr_last_s;
  logic                    pick_dma_s;
  logic                    cpu_gnt_r, cpu_gnt_s;
  logic                    dma_gnt_r, dma_gnt_s;
  logic                    cpu_rvalid_r, cpu_rvalid_s;
  logic                    dma_rvalid_r, dma_rvalid_s;
  logic [DATA_WIDTH-1:0]   cpu_rdata_r, cpu_rdata_s;
  logic [DATA_WIDTH-1:0]   dma_rdata_r, dma_rdata_s;
  logic [ADDR_WIDTH-1:0]   ram_addr_r, ram_addr_s;
  logic                    ram_we_r, ram_we_s;
  logic [DATA_WIDTH-1:0]   ram_wdata_r, ram_wdata_s;
  logic                    busy_r;

`ifdef RAM_ARB_CPU_PRIORITY_EN
  logic [3:0]              hold_cnt_r, hold_cnt_s;

  // Winner selection: CPU first unless DMA has waited through MAX_HOLD CPU grants
  always_comb begin
    if (dma_req && (!cpu_req || (hold_cnt_r == 4'(MAX_HOLD)))) begin
      pick_dma_s = 1'b1;
    end else begin
      pick_dma_s = 1'b0;
    end
  end

  // Starvation counter: counts CPU grants taken while DMA was also asking
  always_comb begin
    hold_cnt_s = hold_cnt_r;
    if ((state_r == ST_IDLE) && (cpu_req || dma_req)) begin
      if (pick_dma_s || !dma_req) begin
        hold_cnt_s = 4'd0;
      end else begin
        hold_cnt_s = hold_cnt_r + 4'd1;
      end
    end else begin
      hold_cnt_s = hold_cnt_r;
    end
  end

  // Starvation counter register
  always_ff @(posedge clock or posedge bReset) begin
    if (bReset) begin
      hold_cnt_r <= 4'd0;
    end else begin
      hold_cnt_r <= hold_cnt_s;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{4'(MAX_HOLD)};

  // Winner selection: a lone requester wins, a tie goes to the port not served last
  always_comb begin
    if (dma_req && (!cpu_req || (rr_last_r == PORT_CPU))) begin
      pick_dma_s = 1'b1;
    end else begin
      pick_dma_s = 1'b0;
    end
  end
`endif

  // Next-state and next-output logic for the IDLE -> ACC -> (RD) -> IDLE sequence
  always_comb begin
    state_s      = state_r;
    winner_s     = winner_r;
    rr_last_s    = rr_last_r;
    cpu_gnt_s    = 1'b0;
    dma_gnt_s    = 1'b0;
    cpu_rvalid_s = 1'b0;
    dma_rvalid_s = 1'b0;
    cpu_rdata_s  = cpu_rdata_r;
    dma_rdata_s  = dma_rdata_r;
    ram_addr_s   = ram_addr_r;
    ram_we_s     = 1'b0;
    ram_wdata_s  = ram_wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          winner_s  = pick_dma_s;
          rr_last_s = pick_dma_s;
          state_s   = ST_ACC;
          if (pick_dma_s) begin
            dma_gnt_s   = 1'b1;
            ram_addr_s  = dma_addr;
            ram_we_s    = dma_we;
            ram_wdata_s = dma_wdata;
          end else begin
            cpu_gnt_s   = 1'b1;
            ram_addr_s  = cpu_addr;
            ram_we_s    = cpu_we;
            ram_wdata_s = cpu_wdata;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (ram_we_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RD;
        end
      end
      ST_RD: begin
        state_s = ST_IDLE;
        if (winner_r == PORT_DMA) begin
          dma_rdata_s  = ram_rdata;
          dma_rvalid_s = 1'b1;
        end else begin
          cpu_rdata_s  = ram_rdata;
          cpu_rvalid_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any read in flight
  always_ff @(posedge clock or posedge bReset) begin
    if (bReset) begin
      state_r      <= ST_IDLE;
      winner_r     <= PORT_CPU;
      rr_last_r    <= PORT_DMA;
      cpu_gnt_r    <= 1'b0;
      dma_gnt_r    <= 1'b0;
      cpu_rvalid_r <= 1'b0;
      dma_rvalid_r <= 1'b0;
      cpu_rdata_r  <= '0;
      dma_rdata_r  <= '0;
      ram_addr_r   <= '0;
      ram_we_r     <= 1'b0;
      ram_wdata_r  <= '0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      winner_r     <= winner_s;
      rr_last_r    <= rr_last_s;
      cpu_gnt_r    <= cpu_gnt_s;
      dma_gnt_r    <= dma_gnt_s;
      cpu_rvalid_r <= cpu_rvalid_s;
      dma_rvalid_r <= dma_rvalid_s;
      cpu_rdata_r  <= cpu_rdata_s;
      dma_rdata_r  <= dma_rdata_s;
      ram_addr_r   <= ram_addr_s;
      ram_we_r     <= ram_we_s;
      ram_wdata_r  <= ram_wdata_s;
      busy_r       <= (state_s != ST_IDLE);
    end
  end

  assign cpu_gnt    = cpu_gnt_r;
  assign dma_gnt    = dma_gnt_r;
  assign cpu_rvalid = cpu_rvalid_r;
  assign dma_rvalid = dma_rvalid_r;
  assign cpu_rdata  = cpu_rdata_r;
  assign dma_rdata  = dma_rdata_r;
  assign ram_addr   = ram_addr_r;
  assign ram_we     = ram_we_r;
  assign ram_wdata  = ram_wdata_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table, directed reset cases and randomized
// traffic scored against a transaction-level arbitration/memory model.
module tb_ram_arbiter;

  localparam int MH = 2;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
  } txn_t;

  typedef struct {
    logic       is_dma;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  logic       clock = 1'b0;
  logic       bReset = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [3:0] cpu_addr = 4'd0;
  logic [7:0] cpu_wdata = 8'd0;
  logic       dma_req = 1'b0, dma_we = 1'b0;
  logic [3:0] dma_addr = 4'd0;
  logic [7:0] dma_wdata = 8'd0;
  logic       cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, ram_we, busy;
  logic [7:0] cpu_rdata, dma_rdata, ram_wdata;
  logic [7:0] ram_rdata = 8'd0;
  logic [3:0] ram_addr;

  logic [7:0] mem [16];
  logic [7:0] ref_mem [16];
  logic       preload = 1'b1;

  txn_t cpu_q[$];
  txn_t dma_q[$];
  int   order_q[$];
  int   m_last;
  int   m_hold;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[8];

  ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .MAX_HOLD(MH)) dut (
    .clock(clock), .bReset(bReset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // RAM macro: synchronous write, read data one cycle after the address edge
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      mem[5] <= 8'h77;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arbitration: lone requester wins; ties follow the policy of the build
  function automatic int model_pick(input bit c, input bit d);
    if (c && !d) return 0;
    if (d && !c) return 1;
`ifdef RAM_ARB_CPU_PRIORITY_EN
    return (m_hold == MH) ? 1 : 0;
`else
    return (m_last == 0) ? 1 : 0;
`endif
  endfunction

  task automatic model_grant(input int w, input bit d);
    m_last = w;
    if (w == 1 || !d) m_hold = 0;
    else m_hold = m_hold + 1;
  endtask

  task automatic drive_reqs();
    cpu_req = (cpu_q.size() > 0);
    dma_req = (dma_q.size() > 0);
    if (cpu_q.size() > 0) begin
      cpu_we = cpu_q[0].we; cpu_addr = cpu_q[0].addr; cpu_wdata = cpu_q[0].wdata;
    end
    if (dma_q.size() > 0) begin
      dma_we = dma_q[0].we; dma_addr = dma_q[0].addr; dma_wdata = dma_q[0].wdata;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    bReset = 1'b1;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    m_last = 1;
    m_hold = 0;
    repeat (2) @(negedge clock);
    bReset = 1'b0;
  endtask

  // Serve both queues to completion, checking every cycle against the model
  task automatic run_engine();
    int   busy_end = -2;
    int   due_c = -1, due_d = -1;
    logic [7:0] exp_c = 8'h00, exp_d = 8'h00;
    bit   cpend, dpend, done = 1'b0;
    int   w;
    txn_t t;
    order_q.delete();
    drive_reqs();
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      cpend = cpu_req;
      dpend = dma_req;
      @(posedge clock);
      #1;
      if (cyc >= busy_end + 2 && (cpend || dpend)) begin
        w = model_pick(cpend, dpend);
        check("cpu_gnt", cpu_gnt, (w == 0));
        check("dma_gnt", dma_gnt, (w == 1));
        order_q.push_back(dma_gnt ? 1 : (cpu_gnt ? 0 : 9));
        if (w == 0) t = cpu_q.pop_front();
        else t = dma_q.pop_front();
        model_grant(w, dpend);
        check("ram_addr", ram_addr, t.addr);
        check("ram_we", ram_we, t.we);
        if (t.we) begin
          check("ram_wdata", ram_wdata, t.wdata);
          ref_mem[t.addr] = t.wdata;
          busy_end = cyc;
        end else begin
          busy_end = cyc + 1;
          if (w == 0) begin due_c = cyc + 2; exp_c = ref_mem[t.addr]; end
          else begin due_d = cyc + 2; exp_d = ref_mem[t.addr]; end
        end
      end else begin
        check("idle_cpu_gnt", cpu_gnt, 1'b0);
        check("idle_dma_gnt", dma_gnt, 1'b0);
        check("idle_ram_we", ram_we, 1'b0);
      end
      check("busy", busy, (cyc <= busy_end));
      check("cpu_rvalid", cpu_rvalid, (due_c == cyc));
      check("dma_rvalid", dma_rvalid, (due_d == cyc));
      if (due_c == cyc) check("cpu_rdata", cpu_rdata, exp_c);
      if (due_d == cyc) check("dma_rdata", dma_rdata, exp_d);
      drive_reqs();
      if (cpu_q.size() == 0 && dma_q.size() == 0 && cyc >= busy_end + 1) done = 1'b1;
    end
    if (!done) check("engine_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    txn_t t;
    int   ok;
    int   exp_order[6];

    vecs[0] = '{1'b0, 1'b1, 4'd3,  8'h2A, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 4'd5,  8'h00, 8'h77};
    vecs[2] = '{1'b0, 1'b0, 4'd3,  8'h00, 8'h2A};
    vecs[3] = '{1'b1, 1'b1, 4'd0,  8'hFF, 8'h00};
    vecs[4] = '{1'b0, 1'b0, 4'd0,  8'h00, 8'hFF};
    vecs[5] = '{1'b1, 1'b0, 4'd3,  8'h00, 8'h2A};
    vecs[6] = '{1'b0, 1'b1, 4'd15, 8'h5C, 8'h00};
    vecs[7] = '{1'b1, 1'b0, 4'd15, 8'h00, 8'h5C};
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    ref_mem[5] = 8'h77;

    // reset state
    do_reset();
    preload = 1'b0;
    #1;
    check("rst_cpu_gnt", cpu_gnt, 1'b0);
    check("rst_dma_gnt", dma_gnt, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_addr", ram_addr, 4'd0);
    check("rst_rvalid", {cpu_rvalid, dma_rvalid}, 2'b00);

    // vector table, one transaction at a time
    for (int i = 0; i < 8; i++) begin
      t = '{vecs[i].we, vecs[i].addr, vecs[i].wdata};
      if (vecs[i].is_dma) dma_q.push_back(t);
      else cpu_q.push_back(t);
      run_engine();
      if (!vecs[i].we) begin
        if (vecs[i].is_dma) check("vec_dma_rdata", dma_rdata, vecs[i].exp_rdata);
        else check("vec_cpu_rdata", cpu_rdata, vecs[i].exp_rdata);
      end
    end

    // asynchronous reset while idle
    @(negedge clock);
    #2 bReset = 1'b1;
    #1;
    check("async_ram_addr", ram_addr, 4'd0);
    check("async_ram_wdata", ram_wdata, 8'd0);
    check("async_rdata", {cpu_rdata, dma_rdata}, 16'd0);
    check("async_busy", busy, 1'b0);
    m_last = 1;
    m_hold = 0;
    @(negedge clock);
    bReset = 1'b0;

    // both continuously requesting from reset
`ifdef RAM_ARB_CPU_PRIORITY_EN
    for (int i = 0; i < 4; i++) cpu_q.push_back('{1'b1, 4'(i + 8), 8'(i + 1)});
    for (int i = 0; i < 2; i++) dma_q.push_back('{1'b1, 4'(i + 12), 8'(i + 16)});
    exp_order = '{0, 0, 1, 0, 0, 1};
`else
    for (int i = 0; i < 3; i++) cpu_q.push_back('{1'b1, 4'(i + 8), 8'(i + 1)});
    for (int i = 0; i < 3; i++) dma_q.push_back('{1'b1, 4'(i + 12), 8'(i + 16)});
    exp_order = '{0, 1, 0, 1, 0, 1};
`endif
    run_engine();
    for (int i = 0; i < 6; i++) begin
      check("grant_order", (i < order_q.size()) ? order_q[i] : -1, exp_order[i]);
    end

    // reset during RD of a CPU read drops the rvalid
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd9;
    ok = 0;
    for (int i = 0; i < 10 && ok == 0; i++) begin
      @(posedge clock);
      #1;
      if (cpu_gnt) ok = 1;
    end
    check("t6_gnt_seen", ok, 1);
    cpu_req = 1'b0;
    @(posedge clock);
    #1;
    check("t6_busy_rd", busy, 1'b1);
    #2 bReset = 1'b1;
    #1;
    check("t6_busy_rst", busy, 1'b0);
    check("t6_rvalid_rst", cpu_rvalid, 1'b0);
    m_last = 1;
    m_hold = 0;
    @(negedge clock);
    bReset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("t6_no_rvalid", cpu_rvalid, 1'b0);
    end
    cpu_q.push_back('{1'b0, 4'd9, 8'h00});
    dma_q.push_back('{1'b0, 4'd3, 8'h00});
    run_engine();
    check("t6_first_cpu", (order_q.size() > 0) ? order_q[0] : -1, 0);

    // randomized traffic
    for (int r = 0; r < 25; r++) begin
      int nc = $urandom_range(0, 3);
      int nd = $urandom_range(0, 3);
      for (int i = 0; i < nc; i++) cpu_q.push_back('{1'($urandom), 4'($urandom), 8'($urandom)});
      for (int i = 0; i < nd; i++) dma_q.push_back('{1'($urandom), 4'($urandom), 8'($urandom)});
      run_engine();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Arbitrates the shared single-port system RAM between two requesters: the CPU control path (port CPU) and the program loader/DMA engine (port DMA). Each requester raises a held request; the arbiter grants one access at a time, drives the RAM address/write strobe/data, and returns read data with a valid pulse. It sits between the control/bus logic and the RAM macro, so RAM can be loaded or inspected while the CPU runs.

Parameters:
ADDR_WIDTH, 4, RAM address width (16 locations).
DATA_WIDTH, 8, RAM data width.
MAX_HOLD, 4, maximum consecutive CPU grants while DMA waits (used only with RAM_ARB_CPU_PRIORITY_EN); legal range 1..15.

Ports:
clock  input  1  system clock, all state on posedge
bReset  input  1  asynchronous, active-high reset
cpu_req  input  1  CPU access request, held until cpu_gnt seen
cpu_we  input  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  input  ADDR_WIDTH  CPU address; stable while cpu_req
cpu_wdata  input  DATA_WIDTH  CPU write data; stable while cpu_req
cpu_gnt  output  1  one-cycle grant pulse; access is being performed
cpu_rvalid  output  1  one-cycle pulse, cpu_rdata valid
cpu_rdata  output  DATA_WIDTH  registered read data
dma_req, dma_we, dma_addr, dma_wdata  input  1/1/ADDR_WIDTH/DATA_WIDTH  DMA equivalents
dma_gnt, dma_rvalid, dma_rdata  output  1/1/DATA_WIDTH  DMA equivalents
ram_addr  output  ADDR_WIDTH  RAM address, registered
ram_we  output  1  RAM write enable, registered
ram_wdata  output  DATA_WIDTH  RAM write data, registered
ram_rdata  input  DATA_WIDTH  RAM read data, valid one cycle after the address edge
busy  output  1  state != IDLE

Behaviour:
- Reset (bReset high, asynchronous): state IDLE; all outputs 0; rr_last = DMA (first tie goes to CPU); hold_cnt 0. A read in flight is dropped, and no rvalid is issued for it.
- States: IDLE, ACC, RD. Arbitration happens only in IDLE.
- IDLE: at posedge, if any req is high, pick a winner and load ram_addr/ram_we/ram_wdata from that port. Winner gnt goes to 1; state -> ACC. If no req is high, stay in IDLE with ram_we 0.
- ACC (1 cycle): winner gnt = 1; ram_* hold the transaction; the RAM samples at the closing edge. At that edge gnt and ram_we go to 0. A write goes -> IDLE; a read goes -> RD.
- RD (1 cycle): ram_addr is held. At the closing edge, capture ram_rdata into the winner's rdata, pulse the winner's rvalid, and go -> IDLE.
- rvalid is high only during the IDLE cycle after RD. rdata holds its value until the next read for that port.
- Requester rule: at the edge that ends the gnt cycle, the requester drops req or presents the next transaction. Because the following state is IDLE or RD, no double grant occurs.
- Latency from the sampling edge E0:
  - gnt is in [E0,E1).
  - Write is committed at E1.
  - rvalid is in [E2,E3).
  - Throughput is 1 write per 2 cycles or 1 read per 3 cycles.
- Default arbitration is round-robin:
  - Single requester wins.
  - If both request, the port not equal to rr_last wins.
  - rr_last updates on every grant.
- ram_addr/ram_wdata keep their last values in IDLE. ram_we is 1 only in ACC for writes.
- Simultaneous bReset and request: reset wins.
- A request is never lost while IDLE; the losing request simply waits.

Optional Feature:
Macro RAM_ARB_CPU_PRIORITY_EN.
- Defined: fixed CPU priority with a starvation guard.
  - hold_cnt counts consecutive CPU grants issued while dma_req was high.
  - When hold_cnt == MAX_HOLD and dma_req is high, DMA wins.
  - hold_cnt resets to 0 on any DMA grant, or on a CPU grant with dma_req low.
- Undefined: round-robin as above; hold_cnt logic and MAX_HOLD are unused.

Test Plan:
1. Assert bReset mid-idle -> all outputs 0 and busy 0, asynchronously (before the next clock edge).
2. CPU write alone, addr 3, data 0x2A -> cpu_gnt=1, ram_we=1, ram_addr=3, ram_wdata=0x2A for exactly one cycle, then IDLE; dma_gnt stays 0.
3. DMA read addr 5, RAM model holding 0x77 -> dma_gnt in cycle 1, busy through RD, dma_rvalid=1 with dma_rdata=0x77 in cycle 3; cpu_rvalid stays 0.
4. Both requesting continuously after reset (default build) -> grant order CPU, DMA, CPU, DMA.
5. RAM_ARB_CPU_PRIORITY_EN, MAX_HOLD=2, both continuous -> grant order CPU, CPU, DMA, CPU, CPU, DMA. With dma_req low, CPU-only grants never stall.
6. bReset pulsed during RD of a CPU read of addr 9 -> no cpu_rvalid, state IDLE, and the next contention after reset is granted to CPU.
